// File: rtl/frequency_analyzer_sequencer.sv
// Round-robin start/stop gate sequencer for a bank of frequency analyzers.
// Outputs are registered (1-cycle latency); no backpressure, free-running while enable is high.
module frequency_analyzer_sequencer #(
  parameter int CHANNELS     = 2,
  parameter int CLOCK        = 100000000,
  parameter int FREQUENCY    = 2000,
  parameter int SIGNAL_DELAY = 20,
  parameter int CNT_WIDTH    = 32,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 period_load,
  input  logic [CNT_WIDTH-1:0] period_value,
  output logic [CHANNELS-1:0]  start,
  output logic [CHANNELS-1:0]  stop,
  output logic                 window_done,
  output logic [CH_W-1:0]      window_channel,
  output logic [CNT_WIDTH-1:0] period_active
);

  localparam longint unsigned RESET_PERIOD_L = longint'(CLOCK) / longint'(FREQUENCY);
  localparam logic [CNT_WIDTH-1:0] RESET_PERIOD = CNT_WIDTH'(RESET_PERIOD_L);
  localparam logic [CNT_WIDTH-1:0] PULSE_LEN    = CNT_WIDTH'(SIGNAL_DELAY);
  localparam logic [CNT_WIDTH-1:0] MIN_PERIOD   = CNT_WIDTH'(SIGNAL_DELAY + 1);
  localparam logic [CH_W-1:0]      LAST_SLOT    = CH_W'(CHANNELS - 1);
  localparam logic [CHANNELS-1:0]  ONE_HOT0     = CHANNELS'(1);

  generate
    if (CHANNELS < 1) begin : g_bad_channels
      $error("CHANNELS must be >= 1");
    end
    if (SIGNAL_DELAY < 1) begin : g_bad_delay
      $error("SIGNAL_DELAY must be >= 1");
    end
    if (CNT_WIDTH < 64 && RESET_PERIOD_L >= (64'd1 << CNT_WIDTH)) begin : g_bad_width
      $error("CLOCK/FREQUENCY does not fit CNT_WIDTH");
    end
  endgenerate

  logic [CNT_WIDTH-1:0] tick_q, tick_d;
  logic [CH_W-1:0]      slot_q, slot_d;
  logic                 primed_q, primed_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] shadow_q, shadow_d;
  logic                 pending_q, pending_d;
  logic [CHANNELS-1:0]  start_q, start_d;
  logic [CHANNELS-1:0]  stop_q, stop_d;
  logic                 done_q, done_d;
  logic [CH_W-1:0]      wch_q, wch_d;
  logic [CH_W-1:0]      prev_slot;

  assign prev_slot = (slot_q == '0) ? LAST_SLOT : slot_q - CH_W'(1);

  always_comb begin
    tick_d    = tick_q;
    slot_d    = slot_q;
    primed_d  = primed_q;
    period_d  = period_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    start_d   = '0;
    stop_d    = '0;
    done_d    = 1'b0;
    wch_d     = '0;

    if (enable) begin
      if (tick_q < PULSE_LEN) begin
        start_d = ONE_HOT0 << slot_q;
        if (primed_q) begin
          stop_d = ONE_HOT0 << prev_slot;
        end
      end
      if (tick_q == '0 && primed_q) begin
        done_d = 1'b1;
        wch_d  = prev_slot;
      end
      // Period reload only at the window boundary so a window is never resized mid-flight.
      if (tick_q == period_q - CNT_WIDTH'(1)) begin
        tick_d   = '0;
        slot_d   = (slot_q == LAST_SLOT) ? '0 : slot_q + CH_W'(1);
        primed_d = 1'b1;
        if (pending_q) begin
          period_d  = shadow_q;
          pending_d = 1'b0;
        end
      end else begin
        tick_d = tick_q + CNT_WIDTH'(1);
      end
    end else begin
      tick_d   = '0;
      slot_d   = '0;
      primed_d = 1'b0;
    end

    // A load on the wrap cycle re-arms pending, so it lands at the following wrap.
    if (period_load) begin
      shadow_d  = (period_value < MIN_PERIOD) ? MIN_PERIOD : period_value;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      tick_q    <= '0;
      slot_q    <= '0;
      primed_q  <= 1'b0;
      period_q  <= RESET_PERIOD;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      start_q   <= '0;
      stop_q    <= '0;
      done_q    <= 1'b0;
      wch_q     <= '0;
    end else begin
      tick_q    <= tick_d;
      slot_q    <= slot_d;
      primed_q  <= primed_d;
      period_q  <= period_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      done_q    <= done_d;
      wch_q     <= wch_d;
    end
  end

  assign start          = start_q;
  assign stop           = stop_q;
  assign window_done    = done_q;
  assign window_channel = wch_q;
  assign period_active  = period_q;

endmodule

// File: tb/tb_frequency_analyzer_sequencer.sv
// Bench for frequency_analyzer_sequencer: 2- and 3-channel instances on shared stimulus,
// checked against a window-level reference model, a directed vector table and corner sequences.
module tb_frequency_analyzer_sequencer;

  localparam int SD = 4;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        period_load;
  logic [31:0] period_value;

  logic [1:0]  start2, stop2;
  logic        done2;
  logic [0:0]  wch2;
  logic [31:0] per2;
  logic [2:0]  start3, stop3;
  logic        done3;
  logic [1:0]  wch3;
  logic [31:0] per3;

  int checks = 0;
  int errors = 0;

  frequency_analyzer_sequencer #(
    .CHANNELS(2), .CLOCK(100), .FREQUENCY(1), .SIGNAL_DELAY(SD), .CNT_WIDTH(32)
  ) dut2 (
    .clock(clock), .reset(reset), .enable(enable),
    .period_load(period_load), .period_value(period_value),
    .start(start2), .stop(stop2), .window_done(done2),
    .window_channel(wch2), .period_active(per2)
  );

  frequency_analyzer_sequencer #(
    .CHANNELS(3), .CLOCK(100), .FREQUENCY(1), .SIGNAL_DELAY(SD), .CNT_WIDTH(32)
  ) dut3 (
    .clock(clock), .reset(reset), .enable(enable),
    .period_load(period_load), .period_value(period_value),
    .start(start3), .stop(stop3), .window_done(done3),
    .window_channel(wch3), .period_active(per3)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: windows counted by index since enable, position measured from window start.
  int       m_run[2], m_widx[2], m_wstart[2], m_per[2], m_shadow[2];
  bit       m_pend[2];
  logic [2:0] e_start[2], e_stop[2];
  bit       e_done[2];
  int       e_wch[2];

  task automatic model_step(input int i);
    int ch_n;
    int pos;
    ch_n = (i == 0) ? 2 : 3;
    e_start[i] = '0;
    e_stop[i]  = '0;
    e_done[i]  = 1'b0;
    e_wch[i]   = 0;
    if (!reset) begin
      m_run[i] = 0; m_widx[i] = 0; m_wstart[i] = 0;
      m_per[i] = 100; m_shadow[i] = 0; m_pend[i] = 1'b0;
      return;
    end
    if (enable) begin
      pos = m_run[i] - m_wstart[i];
      if (pos < SD) begin
        e_start[i] = 3'(1) << (m_widx[i] % ch_n);
        if (m_widx[i] > 0) e_stop[i] = 3'(1) << ((m_widx[i] - 1) % ch_n);
      end
      if (pos == 0 && m_widx[i] > 0) begin
        e_done[i] = 1'b1;
        e_wch[i]  = (m_widx[i] - 1) % ch_n;
      end
      if (pos == m_per[i] - 1) begin
        m_widx[i]   = m_widx[i] + 1;
        m_wstart[i] = m_run[i] + 1;
        if (m_pend[i]) begin
          m_per[i]  = m_shadow[i];
          m_pend[i] = 1'b0;
        end
      end
      m_run[i] = m_run[i] + 1;
    end else begin
      m_run[i] = 0; m_widx[i] = 0; m_wstart[i] = 0;
    end
    if (period_load) begin
      m_shadow[i] = (int'(period_value) < SD + 1) ? SD + 1 : int'(period_value);
      m_pend[i]   = 1'b1;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_pack(input int i);
    logic [1:0] w;
    w = e_done[i] ? 2'(e_wch[i]) : 2'b0;
    return {23'b0, e_start[i], e_stop[i], e_done[i], w, 32'(m_per[i])};
  endfunction

  task automatic tick();
    logic [1:0] w2, w3;
    for (int i = 0; i < 2; i++) model_step(i);
    @(posedge clock);
    #1;
    w2 = e_done[0] ? {1'b0, wch2} : 2'b0;
    w3 = e_done[1] ? wch3 : 2'b0;
    check("model_ch2", {23'b0, 1'b0, start2, 1'b0, stop2, done2, w2, per2}, exp_pack(0));
    check("model_ch3", {23'b0, start3, stop3, done3, w3, per3}, exp_pack(1));
  endtask

  typedef struct {
    int         cyc;
    bit         ld;
    int         val;
    logic [1:0] st;
    logic [1:0] sp;
    bit         dn;
    bit         wc;
    int         per;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs[NVEC];

  function automatic vec_t mk(input int c, input bit l, input int v, input logic [1:0] st,
                              input logic [1:0] sp, input bit dn, input bit wc, input int per);
    vec_t r;
    r.cyc = c; r.ld = l; r.val = v; r.st = st; r.sp = sp; r.dn = dn; r.wc = wc; r.per = per;
    return r;
  endfunction

  initial begin
    int vi;
    logic [1:0] wv;
    vecs[0]  = mk(0,   0, 0,  2'b01, 2'b00, 0, 0, 100);
    vecs[1]  = mk(3,   0, 0,  2'b01, 2'b00, 0, 0, 100);
    vecs[2]  = mk(4,   0, 0,  2'b00, 2'b00, 0, 0, 100);
    vecs[3]  = mk(99,  0, 0,  2'b00, 2'b00, 0, 0, 100);
    vecs[4]  = mk(100, 0, 0,  2'b10, 2'b01, 1, 0, 100);
    vecs[5]  = mk(101, 0, 0,  2'b10, 2'b01, 0, 0, 100);
    vecs[6]  = mk(103, 0, 0,  2'b10, 2'b01, 0, 0, 100);
    vecs[7]  = mk(104, 0, 0,  2'b00, 2'b00, 0, 0, 100);
    vecs[8]  = mk(130, 1, 50, 2'b00, 2'b00, 0, 0, 100);
    vecs[9]  = mk(198, 0, 0,  2'b00, 2'b00, 0, 0, 100);
    vecs[10] = mk(200, 0, 0,  2'b01, 2'b10, 1, 1, 50);
    vecs[11] = mk(249, 0, 0,  2'b00, 2'b00, 0, 0, 50);
    vecs[12] = mk(250, 0, 0,  2'b10, 2'b01, 1, 0, 50);
    vecs[13] = mk(254, 0, 0,  2'b00, 2'b00, 0, 0, 50);
    vecs[14] = mk(260, 1, 2,  2'b00, 2'b00, 0, 0, 50);
    vecs[15] = mk(300, 0, 0,  2'b01, 2'b10, 1, 1, 5);
    vecs[16] = mk(304, 0, 0,  2'b00, 2'b00, 0, 0, 5);
    vecs[17] = mk(305, 0, 0,  2'b10, 2'b01, 1, 0, 5);
    vecs[18] = mk(310, 0, 0,  2'b01, 2'b10, 1, 1, 5);

    reset = 1'b0; enable = 1'b0; period_load = 1'b0; period_value = '0;
    repeat (3) tick();
    check("reset_state_ch2", {26'b0, start2, stop2, done2, wch2, per2}, {26'b0, 2'b00, 2'b00, 1'b0, 1'b0, 32'd100});
    check("reset_state_ch3", {21'b0, start3, stop3, done3, wch3, per3}, {21'b0, 3'b000, 3'b000, 1'b0, 2'b00, 32'd100});
    reset = 1'b1;
    repeat (2) tick();

    // Directed table on the 2-channel instance; edge 0 is the first enabled edge.
    enable = 1'b1;
    vi = 0;
    for (int k = 0; k <= 310; k++) begin
      period_load = 1'b0;
      if (vi < NVEC && vecs[vi].cyc == k) begin
        period_load  = vecs[vi].ld;
        period_value = 32'(vecs[vi].val);
      end
      tick();
      if (vi < NVEC && vecs[vi].cyc == k) begin
        wv = vecs[vi].dn ? {1'b0, wch2} : 2'b0;
        check($sformatf("vec_k%0d", k),
              {23'b0, 1'b0, start2, 1'b0, stop2, done2, wv, per2},
              {23'b0, 1'b0, vecs[vi].st, 1'b0, vecs[vi].sp, vecs[vi].dn,
               vecs[vi].dn ? {1'b0, vecs[vi].wc} : 2'b0, 32'(vecs[vi].per)});
        vi++;
      end
    end
    period_load = 1'b0;

    // Enable dropped in the middle of a start/stop pulse.
    enable = 1'b0;
    tick();
    check("enable_low_outputs", {59'b0, start2, stop2, done2}, 64'd0);
    check("enable_low_keeps_period", {32'b0, per2}, 64'd5);

    // Load while disabled, then restart as a first window.
    period_load = 1'b1; period_value = 32'd20;
    tick();
    period_load = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    check("restart_first_window", {59'b0, start2, stop2, done2}, {59'b0, 2'b01, 2'b00, 1'b0});
    repeat (4) tick();
    tick();
    check("restart_second_window", {27'b0, start2, stop2, done2, per2}, {27'b0, 2'b10, 2'b01, 1'b1, 32'd20});

    // Reset in the middle of a window, then check the 3-channel rotation.
    repeat (7) tick();
    reset = 1'b0;
    tick();
    check("mid_reset_ch3", {21'b0, start3, stop3, done3, wch3, per3}, {21'b0, 3'b000, 3'b000, 1'b0, 2'b00, 32'd100});
    reset = 1'b1;
    for (int k = 0; k <= 300; k++) begin
      tick();
      if (k % 100 == 0)
        check($sformatf("rotation_ch3_k%0d", k), {61'b0, start3}, 64'(3'(1) << ((k / 100) % 3)));
    end

    // Randomized run against the reference model.
    for (int k = 0; k < 4000; k++) begin
      reset        = ($urandom_range(0, 499) != 0);
      enable       = ($urandom_range(0, 99) < 97);
      period_load  = ($urandom_range(0, 19) == 0);
      period_value = 32'($urandom_range(0, 40));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
